tdp_ram_sync_clear: RTL

//  Single-clock true dual-port RAM. Mode, latency and clear value are set by parameters.

---
 rtl/tdp_ram_sync_clear.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tdp_ram_sync_clear.sv
// tdp_ram_sync_clear
//   Single-clock true dual-port RAM. After every reset a built-in sweep writes
//   CLEAR_VALUE to every word. Both ports are held off until the sweep is done.
//   Each port has a valid strobe that marks the read data of an accepted access,
//   so consumers do not have to count latency.
//
// Parameters
//   DATA_WIDTH   word width in bits
//   ADDR_WIDTH   address width, depth = 2**ADDR_WIDTH
//   WRITE_FIRST  0: a write returns the old word on its own port
//                1: a write returns its own write data on its own port
//   OUTPUT_REG   0: read latency 1, 1: extra output register, read latency 2
//   CLEAR_VALUE  word written everywhere by the clear sweep
//
// Ports
//   clock                 rising-edge clock
//   reset                 synchronous, active-high
//   ready                 1 once the sweep is done; ports accept requests
//   enableN, writeN       port N access request / write select
//   addrN, idataN         port N address / write data
//   odataN, validN        port N read data and its valid strobe
//   collision             only when TDP_RAM_COLLISION_EN is defined: high one
//                         cycle after both ports were accepted on the same
//                         address with at least one of them writing
//
// Handshake: an access on port N is accepted in any cycle where
//   ready & enableN is high. validN pulses exactly L = 1 + OUTPUT_REG cycles
//   later, one pulse per accepted access; there is no back-pressure.
//
// Optional feature macro: TDP_RAM_COLLISION_EN

module tdp_ram_sync_clear #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    WRITE_FIRST = 0,
  parameter int                    OUTPUT_REG  = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  enable1,
  input  logic                  write1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] idata1,
  output logic [DATA_WIDTH-1:0] odata1,
  output logic                  valid1,
  input  logic                  enable2,
  input  logic                  write2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] idata2,
  output logic [DATA_WIDTH-1:0] odata2,
  output logic                  valid2
`ifdef TDP_RAM_COLLISION_EN
  ,
  output logic                  collision
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  // One bit wider than the address so the last sweep address never wraps to 0.
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  clear_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc1, acc2;
  logic                  we1, we2;
  logic [DATA_WIDTH-1:0] rd_word1, rd_word2;
  logic [DATA_WIDTH-1:0] next1, next2;
  logic [DATA_WIDTH-1:0] s1_data1, s1_data2;
  logic                  s1_valid1, s1_valid2;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    clear_we = 1'b0;
    if (state_q == ST_CLEAR) begin
      clear_we = 1'b1;
      count_d  = count_q + 1'b1;
      if (count_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  assign ready = (state_q == ST_RUN);

  // ------------------------------------------------------------- memory
  assign acc1 = ready & enable1;
  assign acc2 = ready & enable2;
  assign we1  = acc1 & write1;
  assign we2  = acc2 & write2;

  // Port 1 is written last so it wins a same-address double write.
  // Nothing is written in a reset cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clear_we) begin
        mem[count_q[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
      end else begin
        if (we2) mem[addr2] <= idata2;
        if (we1) mem[addr1] <= idata1;
      end
    end
  end

  // Reads see the array before this cycle's writes, so a cross-port reader
  // always gets the old word; only the own port may forward its write data.
  assign rd_word1 = mem[addr1];
  assign rd_word2 = mem[addr2];
  assign next1    = ((WRITE_FIRST != 0) && write1) ? idata1 : rd_word1;
  assign next2    = ((WRITE_FIRST != 0) && write2) ? idata2 : rd_word2;

  // --------------------------------------------------- first read stage
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_data1  <= '0;
      s1_data2  <= '0;
      s1_valid1 <= 1'b0;
      s1_valid2 <= 1'b0;
    end else begin
      s1_valid1 <= acc1;
      s1_valid2 <= acc2;
      if (acc1) s1_data1 <= next1;
      if (acc2) s1_data2 <= next2;
    end
  end

  // --------------------------------------------- optional output stage
  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data1, s2_data2;
      logic                  s2_valid1, s2_valid2;

      // Plain copy every cycle; holding is done by the first stage.
      always_ff @(posedge clock) begin
        if (reset) begin
          s2_data1  <= '0;
          s2_data2  <= '0;
          s2_valid1 <= 1'b0;
          s2_valid2 <= 1'b0;
        end else begin
          s2_data1  <= s1_data1;
          s2_data2  <= s1_data2;
          s2_valid1 <= s1_valid1;
          s2_valid2 <= s1_valid2;
        end
      end

      assign odata1 = s2_data1;
      assign odata2 = s2_data2;
      assign valid1 = s2_valid1;
      assign valid2 = s2_valid2;
    end else begin : g_no_out_reg
      assign odata1 = s1_data1;
      assign odata2 = s1_data2;
      assign valid1 = s1_valid1;
      assign valid2 = s1_valid2;
    end
  endgenerate

`ifdef TDP_RAM_COLLISION_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      collision <= 1'b0;
    end else begin
      collision <= acc1 & acc2 & (addr1 == addr2) & (write1 | write2);
    end
  end
`endif

endmodule
